board_serial_tx: RTL and testbench

//  Reads the 32-bit board from dp and sends it off-chip to the LED-matrix display driver.
//  - On a frame request, snapshots board_in, error_in and touched_in in the same cycle.
//  - Shifts out a 4-bit header and 32 board bits MSB first, framed by ser_clk and closed by a ser_latch pulse.
//  - Sits between dp board_out/error_out/touched and the chip pads.
//  - Single clock domain: clka.

---
 rtl/board_serial_tx.sv | 156 +++++++++++++++
 tb/tb_board_serial_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/board_serial_tx.sv
// board_serial_tx: snapshots the dp board image on a frame request and
// shifts it off-chip to the LED-matrix driver as a 4-bit header plus
// BOARD_W board bits, MSB first, closed by a latch strobe.
//
// Ports
//   clka        system clock, rising edge
//   restart_n   asynchronous active-low reset
//   board_in    board image (bit BOARD_W-1 = top-left cell)
//   error_in    dp error flag, sent as header bit 2
//   touched_in  dp touched flag, sent as header bit 3
//   frame_req   start one frame (honoured only when idle)
//   busy        high while shifting or latching
//   ser_clk     serial clock, data valid on its rising edge
//   ser_data    serial data
//   ser_latch   display latch strobe, DIV cycles wide
//   frame_done  one-cycle pulse after the latch strobe
module board_serial_tx #(
    parameter int BOARD_W = 32,
    parameter int DIV     = 4
) (
    input  logic               clka,
    input  logic               restart_n,
    input  logic [BOARD_W-1:0] board_in,
    input  logic               error_in,
    input  logic               touched_in,
    input  logic               frame_req,
    output logic               busy,
    output logic               ser_clk,
    output logic               ser_data,
    output logic               ser_latch,
    output logic               frame_done
);

    localparam int FW = BOARD_W + 4;
    localparam int BW = $clog2(FW);
    localparam int DW = $clog2(2 * DIV);

    localparam logic [BW-1:0] BCNT_INIT = BW'(BOARD_W + 3);
    localparam logic [DW-1:0] D_HALF    = DW'(DIV);
    localparam logic [DW-1:0] D_LAST    = DW'(2 * DIV - 1);
    localparam logic [DW-1:0] L_LAST    = DW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    state_t          r_state, w_state_nx;
    logic [FW-1:0]   r_sreg,  w_sreg_nx;
    logic [BW-1:0]   r_bcnt,  w_bcnt_nx;
    logic [DW-1:0]   r_dcnt,  w_dcnt_nx;
    logic            r_busy,  w_busy_nx;
    logic            r_sclk,  w_sclk_nx;
    logic            r_sdat,  w_sdat_nx;
    logic            r_latch, w_latch_nx;
    logic            r_done,  w_done_nx;
    logic [DW-1:0]   w_dcnt_inc;

    assign w_dcnt_inc = r_dcnt + 1'b1;

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_bcnt  <= '0;
            r_dcnt  <= '0;
            r_busy  <= 1'b0;
            r_sclk  <= 1'b0;
            r_sdat  <= 1'b0;
            r_latch <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_sreg  <= w_sreg_nx;
            r_bcnt  <= w_bcnt_nx;
            r_dcnt  <= w_dcnt_nx;
            r_busy  <= w_busy_nx;
            r_sclk  <= w_sclk_nx;
            r_sdat  <= w_sdat_nx;
            r_latch <= w_latch_nx;
            r_done  <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_sreg_nx  = r_sreg;
        w_bcnt_nx  = r_bcnt;
        w_dcnt_nx  = r_dcnt;
        w_busy_nx  = r_busy;
        w_sclk_nx  = r_sclk;
        w_sdat_nx  = r_sdat;
        w_latch_nx = r_latch;
        w_done_nx  = r_done;
        unique case (r_state)
            S_IDLE: begin
                if (frame_req) begin
                    // "10" sync pattern, then the two status LEDs
                    w_sreg_nx  = {1'b1, 1'b0, error_in,
                                  touched_in, board_in};
                    w_bcnt_nx  = BCNT_INIT;
                    w_dcnt_nx  = '0;
                    w_busy_nx  = 1'b1;
                    w_sdat_nx  = 1'b1;
                    w_state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_dcnt == D_LAST) begin
                    w_dcnt_nx = '0;
                    w_sclk_nx = 1'b0;
                    if (r_bcnt != '0) begin
                        // next bit appears with the falling ser_clk
                        w_sreg_nx = {r_sreg[FW-2:0], 1'b0};
                        w_sdat_nx = r_sreg[FW-2];
                        w_bcnt_nx = r_bcnt - 1'b1;
                    end else begin
                        w_sdat_nx  = 1'b0;
                        w_latch_nx = 1'b1;
                        w_state_nx = S_LATCH;
                    end
                end else begin
                    w_dcnt_nx = w_dcnt_inc;
                    w_sclk_nx = (w_dcnt_inc >= D_HALF);
                end
            end
            S_LATCH: begin
                if (r_dcnt == L_LAST) begin
                    w_dcnt_nx  = '0;
                    w_latch_nx = 1'b0;
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                    w_state_nx = S_DONE;
                end else begin
                    w_dcnt_nx = w_dcnt_inc;
                end
            end
            S_DONE: begin
                w_done_nx  = 1'b0;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign busy       = r_busy;
    assign ser_clk    = r_sclk;
    assign ser_data   = r_sdat;
    assign ser_latch  = r_latch;
    assign frame_done = r_done;

endmodule

// File: tb/tb_board_serial_tx.sv
// tb_board_serial_tx: bench for board_serial_tx at DIV=4 and DIV=1,
// a per-cycle timeline model plus directed frame checks.
module tb_board_serial_tx;

    logic        clk = 1'b0;
    logic        restart_n;
    logic [31:0] board;
    logic        err, tch, req_a, req_b;
    logic        busy_a, sck_a, sd_a, lat_a, done_a;
    logic        busy_b, sck_b, sd_b, lat_b, done_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    board_serial_tx #(.BOARD_W(32), .DIV(4)) u_a (
        .clka(clk), .restart_n(restart_n), .board_in(board),
        .error_in(err), .touched_in(tch), .frame_req(req_a),
        .busy(busy_a), .ser_clk(sck_a), .ser_data(sd_a),
        .ser_latch(lat_a), .frame_done(done_a)
    );

    board_serial_tx #(.BOARD_W(32), .DIV(1)) u_b (
        .clka(clk), .restart_n(restart_n), .board_in(board),
        .error_in(err), .touched_in(tch), .frame_req(req_b),
        .busy(busy_b), .ser_clk(sck_b), .ser_data(sd_b),
        .ser_latch(lat_b), .frame_done(done_b)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, req, $time);
        end
    endtask

    // Expected {busy,ser_clk,ser_data,ser_latch,frame_done} in cycle k
    // of a frame (k=1 is the cycle after the accepting edge).
    function automatic logic [4:0] model_out(input bit act, input int k,
                                             input logic [35:0] fr,
                                             input int d);
        logic [4:0] o;
        int t;
        o = '0;
        t = 36 * 2 * d;
        if (act) begin
            if (k >= 1 && k <= t) begin
                o[4] = 1'b1;
                o[3] = ((k - 1) % (2 * d)) >= d;
                o[2] = fr[35 - (k - 1) / (2 * d)];
            end else if (k <= t + d) begin
                o[4] = 1'b1;
                o[1] = 1'b1;
            end else if (k == t + d + 1) begin
                o[0] = 1'b1;
            end
        end
        return o;
    endfunction

    bit          ma_act = 1'b0, mb_act = 1'b0;
    int          ma_k = 0, mb_k = 0;
    logic [35:0] ma_fr = '0, mb_fr = '0;

    always @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            ma_act <= 1'b0;
            ma_k   <= 0;
        end else if (!ma_act) begin
            if (req_a) begin
                ma_act <= 1'b1;
                ma_k   <= 1;
                ma_fr  <= {2'b10, err, tch, board};
            end
        end else if (ma_k >= 36 * 8 + 4 + 1) begin
            ma_act <= 1'b0;
        end else begin
            ma_k <= ma_k + 1;
        end
    end

    always @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            mb_act <= 1'b0;
            mb_k   <= 0;
        end else if (!mb_act) begin
            if (req_b) begin
                mb_act <= 1'b1;
                mb_k   <= 1;
                mb_fr  <= {2'b10, err, tch, board};
            end
        end else if (mb_k >= 36 * 2 + 1 + 1) begin
            mb_act <= 1'b0;
        end else begin
            mb_k <= mb_k + 1;
        end
    end

    always @(negedge clk) begin
        chk("cycle_a", {busy_a, sck_a, sd_a, lat_a, done_a},
            model_out(ma_act, ma_k, ma_fr, 4));
        chk("cycle_b", {busy_b, sck_b, sd_b, lat_b, done_b},
            model_out(mb_act, mb_k, mb_fr, 1));
    end

    logic qa[$];
    always @(posedge sck_a) qa.push_back(sd_a);

    function automatic logic [35:0] qa_bits();
        logic [35:0] v;
        v = '0;
        for (int j = 0; j < qa.size() && j < 36; j++)
            v = {v[34:0], qa[j]};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int nbusy, nlat, ndone, dcyc, nfall, nrise, start2;
        logic pbusy;

        restart_n = 1'b0;
        board = '0; err = 0; tch = 0; req_a = 0; req_b = 0;
        #1;
        chk("rst_a", {busy_a, sck_a, sd_a, lat_a, done_a}, 5'b0);
        chk("rst_b", {busy_b, sck_b, sd_b, lat_b, done_b}, 5'b0);
        repeat (3) tick();
        restart_n = 1'b1;
        tick();

        // single frame, snapshot, requests while busy / in DONE
        board = 32'hA5A5_0F0F; err = 0; tch = 1;
        qa.delete();
        req_a = 1; tick(); req_a = 0;
        nbusy = 0; nlat = 0; ndone = 0; dcyc = 0; nfall = 0;
        pbusy = 1'b1;
        for (int i = 1; i <= 310; i++) begin
            if (busy_a) nbusy++;
            if (lat_a) nlat++;
            if (done_a) begin
                ndone++;
                if (dcyc == 0) dcyc = i;
            end
            if (pbusy && !busy_a) nfall++;
            pbusy = busy_a;
            if (i == 10)  board = 32'hFFFF_FFFF;
            if (i == 50)  req_a = 1;
            if (i == 51)  req_a = 0;
            if (i == 293) req_a = 1;
            if (i == 294) req_a = 0;
            tick();
        end
        chk("busy_cycles", nbusy, 292);
        chk("latch_cycles", nlat, 4);
        chk("done_count", ndone, 1);
        chk("done_cycle", dcyc, 293);
        chk("busy_falls", nfall, 1);
        chk("rise_count", qa.size(), 36);
        chk("frame_bits", qa_bits(), 36'h9_A5A5_0F0F);

        // reset mid-frame, then a fresh frame
        board = 32'hA5A5_0F0F; err = 1; tch = 0;
        req_a = 1; tick(); req_a = 0;
        repeat (100) tick();
        chk("busy_pre_rst", busy_a, 1'b1);
        #4;
        restart_n = 1'b0;
        #1;
        chk("rst_mid_a", {busy_a, sck_a, sd_a, lat_a, done_a}, 5'b0);
        repeat (3) tick();
        restart_n = 1'b1;
        qa.delete();
        board = 32'h1234_5678; err = 0; tch = 0;
        req_a = 1; tick(); req_a = 0;
        dcyc = 0;
        for (int i = 1; i <= 300; i++) begin
            if (done_a && dcyc == 0) dcyc = i;
            tick();
        end
        chk("done_cycle2", dcyc, 293);
        chk("rise_count2", qa.size(), 36);
        chk("frame_bits2", qa_bits(), 36'h8_1234_5678);

        // DIV=1 streaming with frame_req held high
        board = 32'hDEAD_BEEF; err = 1; tch = 1;
        req_b = 1; tick();
        nbusy = 0; nlat = 0; ndone = 0; nrise = 0; start2 = 0;
        pbusy = 1'b0;
        for (int i = 1; i <= 170; i++) begin
            if (busy_b) nbusy++;
            if (lat_b) nlat++;
            if (done_b) ndone++;
            if (!pbusy && busy_b) begin
                nrise++;
                if (nrise == 2) start2 = i;
            end
            pbusy = busy_b;
            if (i == 100) req_b = 0;
            tick();
        end
        chk("b_busy_cycles", nbusy, 146);
        chk("b_latch_cycles", nlat, 2);
        chk("b_done_count", ndone, 2);
        chk("b_frames", nrise, 2);
        chk("b_second_start", start2, 76);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
